// File: rtl/key_cond_pkg.sv
// Shared types and constants for the pushbutton conditioning path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_cond_pkg;

  // Per-key debounce states: two stable states, each with a qualifying state
  // that must see DEBOUNCE_CYCLES consecutive samples before committing.
  typedef enum logic [1:0] {
    UP,
    WAIT_DOWN,
    DOWN,
    WAIT_UP
  } key_state_t;

  // 10 ms of stable input at a 50 MHz clock.
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, counter debouncer, press/release pulses.
// Latency: pin change sampled at edge k shows on key_level after edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; outputs are free-running registers.
//
// Ports:
//   Clk, Reset   - clock, asynchronous active-high reset
//   key_n_in     - raw active-low button, asynchronous to Clk
//   key_level    - debounced level, 1 = pressed
//   key_press    - one-cycle pulse on an accepted press
//   key_release  - one-cycle pulse on an accepted release
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic             r_s1;
  logic             r_s2;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Invert at the first flop so everything downstream is active-high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= ~key_n_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= UP;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // r_cnt holds how many consecutive new-value samples have already been
  // consumed in a WAIT state. The edge that leaves UP/DOWN is the first such
  // sample, so the WAIT state is entered with 1; the commit happens on the
  // sample that would make the run DEBOUNCE_CYCLES long. With a debounce of 1
  // the first differing sample commits directly.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      UP: begin
        if (r_s2) begin
          w_cnt_nxt = ONE_CYCLE ? '0 : CNT_ONE;
          if (ONE_CYCLE) begin
            w_state_nxt = DOWN;
            w_press_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_DOWN;
          end
        end
      end
      WAIT_DOWN: begin
        if (!r_s2) begin
          w_state_nxt = UP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DOWN: begin
        if (!r_s2) begin
          w_cnt_nxt = ONE_CYCLE ? '0 : CNT_ONE;
          if (ONE_CYCLE) begin
            w_state_nxt   = UP;
            w_release_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_UP;
          end
        end
      end
      WAIT_UP: begin
        if (r_s2) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = UP;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = UP;
        w_cnt_nxt   = '0;
      end
    endcase
    // Level follows the committed state, so it moves on the same edge as the pulse.
    w_level_nxt = (w_state_nxt == DOWN) || (w_state_nxt == WAIT_UP);
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS active-low pushbuttons into clean levels, edge pulses and sticky flags.
// Latency: pin change at edge k -> level/pulse after edge k+1+DEBOUNCE_CYCLES; flag one edge later.
// Backpressure: none; event_clear is a level that clears a flag on the next edge.
//
// Ports:
//   Clk, Reset   - clock, asynchronous active-high reset
//   key_n_in     - raw active-low buttons
//   event_clear  - per-key flag clear (level)
//   key_level    - debounced levels, 1 = pressed
//   key_press    - one-cycle press pulses
//   key_release  - one-cycle release pulses
//   event_flags  - sticky press flags; a press beats a simultaneous clear
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_n_in,
  input  logic [N_KEYS-1:0] event_clear,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] event_flags
);

  logic [N_KEYS-1:0] r_event_flags;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .Clk        (Clk),
      .Reset      (Reset),
      .key_n_in   (key_n_in[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

  // Press term is OR-ed last so a set wins over a same-cycle clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_event_flags <= '0;
    end else begin
      r_event_flags <= key_press | (r_event_flags & ~event_clear);
    end
  end

  assign event_flags = r_event_flags;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;

  logic          Clk;
  logic          Reset;
  logic [NK-1:0] key_n_in;
  logic [NK-1:0] event_clear;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] event_flags;

  int n_checks;
  int n_fail;

  key_conditioner #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .key_n_in   (key_n_in),
    .event_clear(event_clear),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .event_flags(event_flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns at the falling edge, where outputs are sampled
  // and new inputs are driven.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clear_flags();
    event_clear = '1;
    tick();
    event_clear = '0;
  endtask

  initial begin
    int n_p;
    int n_r;
    int n_l;
    n_checks    = 0;
    n_fail      = 0;
    Reset       = 1'b1;
    key_n_in    = '1;
    event_clear = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_val("rst_level", 32'(key_level), 32'h0);
    check_val("rst_flags", 32'(event_flags), 32'h0);
    Reset = 1'b0;
    repeat (3) tick();
    check_val("idle_all", 32'({key_level, key_press, key_release, event_flags}), 32'h0);

    // ---------------- all keys held, async reset, re-detect ----------------
    key_n_in = 4'b0000;
    repeat (6) tick();
    check_val("all_press", 32'(key_press), 32'hF);
    tick();
    check_val("all_flags", 32'(event_flags), 32'hF);
    #2 Reset = 1'b1;
    #1;
    check_val("async_rst_level", 32'(key_level), 32'h0);
    check_val("async_rst_flags", 32'(event_flags), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    n_p = 0;
    n_r = 0;
    repeat (5) begin
      tick();
      n_p += int'(key_press != 0);
      n_r += int'(key_release != 0);
    end
    check_val("rst_redetect_early", 32'(n_p + n_r), 32'h0);
    tick();
    check_val("rst_redetect_press", 32'(key_press), 32'hF);
    check_val("rst_redetect_level", 32'(key_level), 32'hF);
    tick();
    check_val("rst_redetect_pulse_w", 32'(key_press), 32'h0);
    key_n_in = 4'b1111;
    repeat (6) tick();
    check_val("all_release", 32'(key_release), 32'hF);
    check_val("all_release_level", 32'(key_level), 32'h0);
    tick();
    clear_flags();
    check_val("flags_cleared", 32'(event_flags), 32'h0);

    // ---------------- clean press / release on key 2 ----------------
    key_n_in = 4'b1011;
    repeat (5) tick();
    check_val("k2_level_early", 32'(key_level), 32'h0);
    tick();
    check_val("k2_press", 32'(key_press), 32'h4);
    check_val("k2_level", 32'(key_level), 32'h4);
    n_p = 0;
    n_r = 0;
    repeat (34) begin
      tick();
      n_p += int'(key_press != 0);
      n_r += int'(key_release != 0);
    end
    check_val("k2_no_extra_pulse", 32'(n_p + n_r), 32'h0);
    key_n_in = 4'b1111;
    repeat (5) tick();
    check_val("k2_release_early", 32'(key_release), 32'h0);
    tick();
    check_val("k2_release", 32'(key_release), 32'h4);
    check_val("k2_level_up", 32'(key_level), 32'h0);
    tick();
    check_val("k2_release_w", 32'(key_release), 32'h0);
    check_val("k2_flags", 32'(event_flags), 32'h4);
    clear_flags();

    // ---------------- bounce on key 1 ----------------
    n_p = 0;
    n_r = 0;
    key_n_in = 4'b1101;
    repeat (3) begin
      tick();
      n_p += int'(key_press != 0);
    end
    key_n_in = 4'b1111;
    repeat (3) begin
      tick();
      n_p += int'(key_press != 0);
    end
    key_n_in = 4'b1101;
    repeat (5) begin
      tick();
      n_p += int'(key_press != 0);
      n_r += int'(key_release != 0);
    end
    check_val("k1_bounce_quiet", 32'(n_p + n_r), 32'h0);
    tick();
    check_val("k1_bounce_press", 32'(key_press), 32'h2);
    n_p = 0;
    repeat (6) begin
      tick();
      n_p += int'(key_press != 0);
      n_r += int'(key_release != 0);
    end
    check_val("k1_single_press", 32'(n_p + n_r), 32'h0);
    key_n_in = 4'b1111;
    repeat (8) tick();
    clear_flags();

    // ---------------- 3-cycle glitch on key 0 ----------------
    n_p = 0;
    n_l = 0;
    key_n_in = 4'b1110;
    repeat (3) begin
      tick();
      n_p += int'(key_press != 0) + int'(key_release != 0);
      n_l += int'(key_level[0]);
    end
    key_n_in = 4'b1111;
    repeat (10) begin
      tick();
      n_p += int'(key_press != 0) + int'(key_release != 0);
      n_l += int'(key_level[0]);
    end
    check_val("k0_glitch_pulses", 32'(n_p), 32'h0);
    check_val("k0_glitch_level", 32'(n_l), 32'h0);
    check_val("k0_glitch_flags", 32'(event_flags), 32'h0);

    // ---------------- set beats clear on key 3 ----------------
    key_n_in = 4'b0111;
    repeat (6) tick();
    check_val("k3_press", 32'(key_press), 32'h8);
    event_clear = 4'b1000;
    tick();
    check_val("k3_set_wins", 32'(event_flags), 32'h8);
    tick();
    check_val("k3_cleared", 32'(event_flags), 32'h0);
    event_clear = '0;
    key_n_in = 4'b1111;
    repeat (8) tick();
    clear_flags();

    // ---------------- reset while key 2 is DOWN ----------------
    key_n_in = 4'b1011;
    repeat (8) tick();
    check_val("k2_down", 32'(key_level), 32'h4);
    #2 Reset = 1'b1;
    #1;
    check_val("k2_rst_level", 32'(key_level), 32'h0);
    check_val("k2_rst_release", 32'(key_release), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    n_p = 0;
    n_r = 0;
    repeat (5) begin
      tick();
      n_p += int'(key_press != 0);
      n_r += int'(key_release != 0);
    end
    check_val("k2_rst_quiet", 32'(n_p + n_r), 32'h0);
    tick();
    check_val("k2_rst_repress", 32'(key_press), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
